// File: rtl/rst_trig_pkg.sv
// Shared constants for the reset trigger block: cause bit layout, IO write
// command bits and the request FSM encoding.
package rst_trig_pkg;

  localparam int CAUSE_W   = 8;
  localparam int CAUSE_POR = 0;
  localparam int CAUSE_SW  = 1;
  localparam int CAUSE_WD  = 2;
  localparam int CAUSE_HW0 = 3;

  localparam int WR_SW   = 0;
  localparam int WR_CLR  = 1;
  localparam int WR_WDLD = 2;
  localparam int WR_KICK = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } state_e;

endpackage

// File: rtl/rst_trig_wdog.sv
// Watchdog for reset_trig (built only with RST_TRIG_WDOG_EN): a TICK_DIV
// prescaler feeding a 16-bit timeout counter that fires once, then disarms.
module rst_trig_wdog #(
  parameter int TICK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        ld_i,
  input  logic        kick_i,
  input  logic [15:0] to_i,
  output logic        expire_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   to_q, to_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          en_q, en_d;
  logic          tick;

  assign tick     = (pre_q == PW'(TICK_DIV - 1));
  // Fires on the tick that would take the count from 1 to 0.
  assign expire_o = en_q & tick & (cnt_q == 16'd1);

  always_comb begin
    pre_d = tick ? '0 : pre_q + PW'(1);
    to_d  = to_q;
    cnt_d = cnt_q;
    en_d  = en_q;
    if (en_q && tick) cnt_d = cnt_q - 16'd1;
    if (expire_o) en_d = 1'b0;
    if (kick_i) begin
      cnt_d = to_q;
      pre_d = '0;
    end
    if (ld_i) begin
      to_d  = to_i;
      cnt_d = to_i;
      pre_d = '0;
      en_d  = |to_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      pre_q <= '0;
      to_q  <= '0;
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      pre_q <= pre_d;
      to_q  <= to_d;
      cnt_q <= cnt_d;
      en_q  <= en_d;
    end
  end

endmodule

// File: rtl/reset_trig.sv
// Reset request initiator: one PULSE_LEN-cycle active-low request per trigger
// event, with a cause register that survives rst. Watchdog under RST_TRIG_WDOG_EN.
module reset_trig
  import rst_trig_pkg::*;
#(
  parameter int NUM_SRC   = 3,
  parameter int PULSE_LEN = 16,
  parameter int TICK_DIV  = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               por,
  input  logic               stb,
  input  logic               we,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  output logic               ack,
  input  logic [NUM_SRC-1:0] trig_in,
  output logic               rst_req_n
);

  localparam int CW = $clog2(PULSE_LEN);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 req_n_q, req_n_d;
  logic [NUM_SRC-1:0]   trig_q, hw_ev;
  logic [CAUSE_W-1:0]   cause_q, cause_d, ev_bits;
  logic                 wr, sw_ev, clr, wd_ev, any_ev;

  assign wr     = stb & we;
  assign sw_ev  = wr & data_in[WR_SW];
  assign clr    = wr & data_in[WR_CLR];
  assign hw_ev  = trig_in & ~trig_q;
  assign any_ev = |ev_bits;

  assign ev_bits[CAUSE_POR] = 1'b0;
  assign ev_bits[CAUSE_SW]  = sw_ev;
  assign ev_bits[CAUSE_WD]  = wd_ev;

  genvar gi;
  generate
    for (gi = 0; gi < CAUSE_W - CAUSE_HW0; gi++) begin : g_hw
      if (gi < NUM_SRC) begin : g_src
        assign ev_bits[CAUSE_HW0+gi] = hw_ev[gi];
      end else begin : g_pad
        assign ev_bits[CAUSE_HW0+gi] = 1'b0;
      end
    end
  endgenerate

`ifdef RST_TRIG_WDOG_EN
  logic unused_data;
  assign unused_data = ^data_in[15:4];

  rst_trig_wdog #(
    .TICK_DIV (TICK_DIV)
  ) u_wdog (
    .clk      (clk),
    .rst_i    (rst | por),
    .ld_i     (wr & data_in[WR_WDLD]),
    .kick_i   (wr & data_in[WR_KICK]),
    .to_i     (data_in[31:16]),
    .expire_o (wd_ev)
  );
`else
  logic unused_data;
  assign unused_data = ^{data_in[31:2], 32'(TICK_DIV)};
  assign wd_ev = 1'b0;
`endif

  // A clear (or a new request from IDLE) replaces the cause; otherwise
  // events arriving during a pulse accumulate.
  always_comb begin
    cause_d = cause_q;
    if (por) begin
      cause_d = CAUSE_W'(1) << CAUSE_POR;
    end else if (!rst) begin
      if (clr || (state_q == IDLE && any_ev)) cause_d = ev_bits;
      else cause_d = cause_q | ev_bits;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_n_d = req_n_q;
    unique case (state_q)
      IDLE: begin
        if (any_ev) begin
          state_d = PULSE;
          cnt_d   = CW'(PULSE_LEN - 1);
          req_n_d = 1'b0;
        end
      end
      PULSE: begin
        req_n_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = IDLE;
          req_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        req_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || por) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_n_q <= 1'b1;
      trig_q  <= trig_in;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_n_q <= req_n_d;
      trig_q  <= trig_in;
    end
  end

  // No reset branch: the cause must outlive the reset it requested.
  always_ff @(posedge clk) begin
    cause_q <= cause_d;
  end

  assign rst_req_n = req_n_q;
  assign ack       = stb;
  assign data_out  = {24'h0, cause_q};

endmodule

// File: tb/tb_reset_trig.sv
// Directed bench for reset_trig (PULSE_LEN=4, NUM_SRC=3, TICK_DIV=10);
// watchdog scenarios are selected by RST_TRIG_WDOG_EN.
module tb_reset_trig;

  localparam int NUM_SRC   = 3;
  localparam int PULSE_LEN = 4;
  localparam int TICK_DIV  = 10;

  logic               clk = 1'b0;
  logic               rst, por, stb, we;
  logic [31:0]        data_in, data_out;
  logic               ack;
  logic [NUM_SRC-1:0] trig_in;
  logic               rst_req_n;

  int errors = 0;
  int checks = 0;

  reset_trig #(
    .NUM_SRC   (NUM_SRC),
    .PULSE_LEN (PULSE_LEN),
    .TICK_DIV  (TICK_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .por       (por),
    .stb       (stb),
    .we        (we),
    .data_in   (data_in),
    .data_out  (data_out),
    .ack       (ack),
    .trig_in   (trig_in),
    .rst_req_n (rst_req_n)
  );

  always #5 clk = ~clk;

  task automatic io_write(input logic [31:0] d);
    stb = 1'b1; we = 1'b1; data_in = d;
    @(negedge clk);
    stb = 1'b0; we = 1'b0; data_in = '0;
  endtask

  task automatic io_read(output logic [31:0] d, output logic a);
    stb = 1'b1; we = 1'b0;
    #1;
    d = data_out; a = ack;
    stb = 1'b0;
  endtask

  // Samples rst_req_n on n consecutive negedges (first one is the current time).
  task automatic measure(input int n, input logic prev0, output int lows, output int falls);
    logic prev;
    prev = prev0; lows = 0; falls = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (rst_req_n === 1'b0) lows++;
      if (prev === 1'b1 && rst_req_n === 1'b0) falls++;
      prev = rst_req_n;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic a;
    rst = 1'b1; por = 1'b1; stb = 1'b0; we = 1'b0; data_in = '0; trig_in = '0;
    repeat (2) @(negedge clk);
    checks++; if (rst_req_n !== 1'b1) begin errors++; $display("FAIL reset_req_n: got %b expected 1", rst_req_n); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack_idle: got %b expected 0", ack); end
    rst = 1'b0; por = 1'b0;
    @(negedge clk);
    io_read(d, a);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL reset_cause: got %h expected 00000001", d); end
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL read_ack: got %b expected 1", a); end
    $display("test_reset: cause=%h", d);
  endtask

  task automatic test_sw();
    logic [31:0] d; logic a;
    checks++; if (rst_req_n !== 1'b1) begin errors++; $display("FAIL sw_pre_high: got %b expected 1", rst_req_n); end
    io_write(32'h1);
    for (int k = 0; k < PULSE_LEN; k++) begin
      checks++; if (rst_req_n !== 1'b0) begin errors++; $display("FAIL sw_pulse_low[%0d]: got %b expected 0", k, rst_req_n); end
      @(negedge clk);
    end
    checks++; if (rst_req_n !== 1'b1) begin errors++; $display("FAIL sw_pulse_end: got %b expected 1", rst_req_n); end
    io_read(d, a);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL sw_cause: got %h expected 00000002", d); end
    $display("test_sw: cause=%h", d);
  endtask

  task automatic test_hw();
    logic [31:0] d; logic a; int lows, falls;
    trig_in = 3'b011;
    @(negedge clk);
    measure(10, 1'b1, lows, falls);
    checks++; if (lows !== 4) begin errors++; $display("FAIL hw_pulse_len: got %0d expected 4", lows); end
    checks++; if (falls !== 1) begin errors++; $display("FAIL hw_pulse_count: got %0d expected 1", falls); end
    trig_in = '0;
    io_read(d, a);
    checks++; if (d !== 32'h18) begin errors++; $display("FAIL hw_cause: got %h expected 00000018", d); end
    $display("test_hw: cause=%h lows=%0d falls=%0d", d, lows, falls);
  endtask

  task automatic test_por();
    logic [31:0] d; logic a; int lows, falls;
    por = 1'b1;
    @(negedge clk);
    por = 1'b0;
    measure(5, 1'b1, lows, falls);
    checks++; if (lows !== 0) begin errors++; $display("FAIL por_no_pulse: got %0d low cycles expected 0", lows); end
    io_read(d, a);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL por_cause: got %h expected 00000001", d); end
    $display("test_por: cause=%h", d);
  endtask

  task automatic test_rst_abort();
    logic [31:0] d; logic a; int lows, falls;
    io_write(32'h1);
    @(negedge clk);
    checks++; if (rst_req_n !== 1'b0) begin errors++; $display("FAIL abort_pre_low: got %b expected 0", rst_req_n); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rst_req_n !== 1'b1) begin errors++; $display("FAIL abort_release: got %b expected 1", rst_req_n); end
    rst = 1'b0;
    measure(6, 1'b1, lows, falls);
    checks++; if (lows !== 0) begin errors++; $display("FAIL abort_stays_high: got %0d low cycles expected 0", lows); end
    io_read(d, a);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL abort_cause_kept: got %h expected 00000002", d); end
    $display("test_rst_abort: cause=%h", d);
  endtask

  task automatic test_clear();
    logic [31:0] d; logic a; int lows, falls;
    trig_in = 3'b001;
    @(negedge clk);
    io_read(d, a);
    checks++; if (d !== 32'h08) begin errors++; $display("FAIL clr_hw0_cause: got %h expected 00000008", d); end
    io_write(32'h3);
    measure(8, 1'b0, lows, falls);
    checks++; if (lows !== 3 || falls !== 0) begin errors++; $display("FAIL clr_single_pulse: got lows=%0d falls=%0d expected lows=3 falls=0", lows, falls); end
    trig_in = '0;
    io_read(d, a);
    checks++; if (d !== 32'h02) begin errors++; $display("FAIL clr_sw_wins: got %h expected 00000002", d); end
    io_write(32'h2);
    measure(6, 1'b1, lows, falls);
    checks++; if (lows !== 0) begin errors++; $display("FAIL clr_no_pulse: got %0d low cycles expected 0", lows); end
    io_read(d, a);
    checks++; if (d !== 32'h00) begin errors++; $display("FAIL clr_cause: got %h expected 00000000", d); end
    $display("test_clear: cause=%h", d);
  endtask

  task automatic test_or_in_pulse();
    logic [31:0] d; logic a; int lows, falls;
    io_write(32'h1);
    trig_in = 3'b100;
    @(negedge clk);
    measure(8, 1'b0, lows, falls);
    checks++; if (lows !== 3 || falls !== 0) begin errors++; $display("FAIL or_single_pulse: got lows=%0d falls=%0d expected lows=3 falls=0", lows, falls); end
    trig_in = '0;
    io_read(d, a);
    checks++; if (d !== 32'h22) begin errors++; $display("FAIL or_cause: got %h expected 00000022", d); end
    $display("test_or_in_pulse: cause=%h", d);
  endtask

`ifdef RST_TRIG_WDOG_EN
  task automatic test_wdog();
    logic [31:0] d; logic a; int lows, falls; int i;
    io_write(32'h0003_0004);
    i = 1;
    while (rst_req_n === 1'b1 && i < 80) begin @(negedge clk); i++; end
    checks++; if (i !== 31) begin errors++; $display("FAIL wd_expiry_cycle: got %0d expected 31", i); end
    measure(8, 1'b0, lows, falls);
    io_read(d, a);
    checks++; if (d !== 32'h04) begin errors++; $display("FAIL wd_cause: got %h expected 00000004", d); end
    measure(45, 1'b1, lows, falls);
    checks++; if (falls !== 0) begin errors++; $display("FAIL wd_one_shot: got %0d pulses expected 0", falls); end
    $display("test_wdog: expiry=%0d cause=%h", i, d);
  endtask

  task automatic test_wdog_kick();
    logic [31:0] d; logic a; int lows, falls; int i;
    io_write(32'h0000_0002);
    io_write(32'h0003_0004);
    repeat (24) @(negedge clk);
    io_write(32'h0000_0008);
    i = 26;
    while (rst_req_n === 1'b1 && i < 120) begin @(negedge clk); i++; end
    checks++; if (i !== 56) begin errors++; $display("FAIL wd_kick_expiry: got %0d expected 56", i); end
    measure(8, 1'b0, lows, falls);
    io_read(d, a);
    checks++; if (d !== 32'h04) begin errors++; $display("FAIL wd_kick_cause: got %h expected 00000004", d); end
    $display("test_wdog_kick: expiry=%0d cause=%h", i, d);
  endtask
`else
  task automatic test_wdog_absent();
    logic [31:0] d; logic a; int lows, falls;
    io_write(32'h0003_0004);
    measure(45, 1'b1, lows, falls);
    checks++; if (falls !== 0) begin errors++; $display("FAIL nowd_no_pulse: got %0d pulses expected 0", falls); end
    io_write(32'h0000_0008);
    measure(5, 1'b1, lows, falls);
    checks++; if (lows !== 0) begin errors++; $display("FAIL nowd_kick_ignored: got %0d low cycles expected 0", lows); end
    io_read(d, a);
    checks++; if (d !== 32'h22) begin errors++; $display("FAIL nowd_cause: got %h expected 00000022", d); end
    $display("test_wdog_absent: cause=%h", d);
  endtask
`endif

  initial begin
    test_reset();
    test_sw();
    test_hw();
    test_por();
    test_rst_abort();
    test_clear();
    test_or_in_pulse();
`ifdef RST_TRIG_WDOG_EN
    test_wdog();
    test_wdog_kick();
`else
    test_wdog_absent();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
